sobel_window_ctrl: RTL
======================

Name: sobel_window_ctrl

Overview:
- Frame-level sequencer for the combinational 3x3 Sobel gradient/threshold datapath.
- Accepts a raster pixel stream and builds the 3x3 window with two line buffers plus a 3x3 register array.
- Drives the window and threshold T into the gradient unit, then captures the unit's Dop decision into a registered, back-pressurable edge stream.
- Sits between the pixel source (camera/DMA) and the edge-map sink.

Parameters:
- NBIT, 8, pixel and threshold width (matches gradient unit nbit)
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE
- thresh  in  NBIT  threshold; sampled into thr_q on accepted start
- pix_valid  in  1  source pixel valid
- pix_ready  out  1  block can accept pixel
- pix_data  in  NBIT  pixel, raster order
- win_p0..win_p8  out  NBIT each  window to gradient P0..P8, row-major, p0 = top-left (oldest line), p4 = centre
- win_t  out  NBIT  thr_q to gradient T
- dop  in  1  gradient result (1 = edge), combinational from win_*
- edge_valid  out  1  edge output valid
- edge_data  out  1  edge bit for interior pixel
- edge_ready  in  1  sink ready
- busy  out  1  high in FILL/RUN
- done  out  1  one-cycle pulse after the last edge is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, col=row=0, window regs=0, thr_q=0, pix_ready=0, edge_valid=0, edge_data=0, busy=0, done=0. Line buffer contents are don't-care.
- States:
  - IDLE: start -> FILL; thr_q<=thresh; col,row<=0.
  - FILL: pixels accepted, no edge output. Transition to RUN at the acceptance of pixel (row=2, col=2).
  - RUN: each accepted pixel with col>=2 produces exactly one edge. After the last edge (row=IMG_H-1, col=IMG_W-1) is accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Pixel accept: pix_valid && pix_ready.
  - pix_ready = (state==FILL || state==RUN) && !(edge_valid && !edge_ready), and pix_ready=0 once the last pixel of the frame has been accepted.
- On accept:
  - window columns shift left.
  - New right column = {lb1_out, lb0_out, pix_data}.
  - lb0 <= pix_data; lb1 <= lb0_out (each line buffer has delay IMG_W).
  - col increments and wraps at IMG_W-1 to 0 with row+1.
- Window window is valid when the accepted pixel has row>=2 && col>=2. It is centred at (row-1, col-1).
  - Cycle after that accept: edge_valid<=1, edge_data<=dop (sampled from the registered window).
  - Latency: 1 cycle from pixel accept to edge_valid.
- Column wrap: on accept with col<2, the window holds mixed lines. No edge is produced; dop is ignored.
- Edge handshake:
  - edge_valid stays high and edge_data stays stable until edge_ready.
  - Simultaneous new-edge load and edge_ready in the same cycle is allowed, giving back-to-back output.
- Output count: exactly (IMG_W-2)*(IMG_H-2) edges per frame. Borders are not emitted.
- thresh changes mid-frame have no effect; only thr_q is used.
- start while busy: ignored.
- rst_n asserted mid-frame: immediate return to reset values. Partial frame is discarded and the next frame needs a new start.

Optional Feature:
- Macro SOBEL_EDGE_COUNT_EN.
- Defined:
  - Adds output port edge_count (32 bits).
  - Cleared on accepted start; increments on each edge handshake with edge_data=1.
  - Holds its value after DONE until the next start.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sobel_pkg:
  - NBIT default.
  - state typedef {IDLE, FILL, RUN, DONE}.
  - Window index constants P0..P8.
- Sub-module sobel_line_buffer:
  - Parameterised depth IMG_W, width NBIT.
  - Circular RAM with a single pointer that advances on an enable.
  - Read-before-write at the same address.
  - Instantiated twice.

Test Plan:
- IMG_W=4, IMG_H=4, thr=8'd50, flat frame of all 8'd10, sink always ready -> 4 edges, all edge_data=0. done pulses 1 cycle after the 4th handshake.
- Same size, left two columns 8'd0 and right two 8'd200 -> 4 edges, all 1. The first edge_valid occurs 1 cycle after the accept of pixel 10 (row 2, col 2).
- IMG_W=5, IMG_H=3, ramp frame, edge_ready toggled 1/0 every cycle -> 3 edges. No edge is dropped or duplicated, edge_data stays stable while stalled, and pix_ready=0 during each stall.
- Mid-frame: start pulse plus a thresh change from 50 to 255 -> ignored; results still use 50 and busy stays 1.
- rst_n pulled low after 7 accepted pixels -> all outputs return to reset values asynchronously. A new start then produces a correct full frame.
- With SOBEL_EDGE_COUNT_EN, the step frame above -> edge_count=4 at done. After a new start, edge_count reads 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the 3x3 Sobel window controller:
//   - NBIT_DEF : default pixel / threshold width
//   - state_t  : frame sequencer states
//   - P0..P8   : window tap indices, row-major, P0 = top-left (oldest line),
//                P4 = centre, P8 = bottom-right (newest pixel)
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int NBIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;
    localparam int P7 = 7;
    localparam int P8 = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// One-line delay (IMG_W enabled cycles) built as a circular RAM addressed by a
// single pointer. The output is the word stored IMG_W enables ago; it is read
// at the pointer before the same location is overwritten.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (pointer only; RAM is don't-care)
//   en_i       advance: write wr_data_i and step the pointer
//   wr_data_i  NBIT  incoming word
//   rd_data_o  NBIT  word written IMG_W enables earlier
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int IMG_W = 640,
    parameter int NBIT  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NBIT-1:0] wr_data_i,
    output logic [NBIT-1:0] rd_data_o
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [NBIT-1:0] mem_q [IMG_W];
    logic [AW-1:0]   ptr_q;

    assign rd_data_o = mem_q[ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= (ptr_q == AW'(IMG_W - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_window_ctrl
// Frame sequencer for a combinational 3x3 Sobel gradient/threshold unit.
// Builds the 3x3 window from a raster pixel stream (two line buffers plus a
// 3x3 register array), presents it with the frame threshold to the gradient
// unit, and captures the unit's decision into a back-pressurable edge stream.
// Only interior pixels produce an edge: (IMG_W-2)*(IMG_H-2) per frame.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle frame start (ignored unless idle)
//   thresh                threshold, captured on accepted start
//   pix_valid/ready/data  pixel input stream (raster order)
//   win_p0..win_p8        window to gradient unit, row-major, p4 = centre
//   win_t                 captured threshold to gradient unit
//   dop                   gradient decision, combinational from win_*
//   edge_valid/data/ready edge output stream
//   busy                  frame in progress (FILL or RUN)
//   done                  one-cycle pulse after the last edge is accepted
//   edge_count            (only with SOBEL_EDGE_COUNT_EN) accepted edges = 1
//
// Build option: define SOBEL_EDGE_COUNT_EN to add the edge_count port.
// -----------------------------------------------------------------------------
module sobel_window_ctrl #(
    parameter int NBIT  = sobel_pkg::NBIT_DEF,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NBIT-1:0] thresh,
    input  logic            pix_valid,
    output logic            pix_ready,
    input  logic [NBIT-1:0] pix_data,
    output logic [NBIT-1:0] win_p0,
    output logic [NBIT-1:0] win_p1,
    output logic [NBIT-1:0] win_p2,
    output logic [NBIT-1:0] win_p3,
    output logic [NBIT-1:0] win_p4,
    output logic [NBIT-1:0] win_p5,
    output logic [NBIT-1:0] win_p6,
    output logic [NBIT-1:0] win_p7,
    output logic [NBIT-1:0] win_p8,
    output logic [NBIT-1:0] win_t,
    input  logic            dop,
    output logic            edge_valid,
    output logic            edge_data,
    input  logic            edge_ready,
    output logic            busy,
    output logic            done
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    output logic [31:0]     edge_count
`endif
);

    import sobel_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [NBIT-1:0] thr_q;
    logic [NBIT-1:0] win_q [9];
    logic            last_acc_q;    // final pixel of the frame already taken
    logic            win_vld_q;     // registered window holds an interior centre
    logic            edge_valid_q;
    logic            edge_data_q;
    logic            done_q;

    logic [NBIT-1:0] lb0_out;
    logic [NBIT-1:0] lb1_out;
    logic            accept;
    logic            interior;
    logic            last_pix;
    logic            transfer;
    logic            last_hs;

    // Stall the source whenever the edge slot is full and not draining, so the
    // pending window can never be overwritten before its decision is taken.
    assign pix_ready = ((state_q == FILL) || (state_q == RUN)) && !last_acc_q
                       && !(edge_valid_q && !edge_ready);
    assign accept    = pix_valid && pix_ready;
    assign interior  = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    // dop is valid one cycle after the window register loads; move it into
    // the edge slot when the slot is empty or being emptied this cycle.
    assign transfer  = win_vld_q && (!edge_valid_q || edge_ready);
    assign last_hs   = edge_valid_q && edge_ready && last_acc_q && !win_vld_q;

    sobel_line_buffer #(.IMG_W(IMG_W), .NBIT(NBIT)) u_lb0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (accept),
        .wr_data_i (pix_data),
        .rd_data_o (lb0_out)
    );

    sobel_line_buffer #(.IMG_W(IMG_W), .NBIT(NBIT)) u_lb1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (accept),
        .wr_data_i (lb0_out),
        .rd_data_o (lb1_out)
    );

    // Window stage: shift left, new right column = {oldest, middle, newest}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (accept) begin
            win_q[P0] <= win_q[P1];
            win_q[P1] <= win_q[P2];
            win_q[P2] <= lb1_out;
            win_q[P3] <= win_q[P4];
            win_q[P4] <= win_q[P5];
            win_q[P5] <= lb0_out;
            win_q[P6] <= win_q[P7];
            win_q[P7] <= win_q[P8];
            win_q[P8] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            thr_q        <= '0;
            last_acc_q   <= 1'b0;
            win_vld_q    <= 1'b0;
            edge_valid_q <= 1'b0;
            edge_data_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Edge stage: load from the window, otherwise drain on ready
            if (transfer) begin
                edge_valid_q <= 1'b1;
                edge_data_q  <= dop;
            end else if (edge_ready) begin
                edge_valid_q <= 1'b0;
            end

            if (accept && interior) begin
                win_vld_q <= 1'b1;
            end else if (transfer) begin
                win_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FILL;
                        thr_q      <= thresh;
                        col_q      <= '0;
                        row_q      <= '0;
                        last_acc_q <= 1'b0;
                    end
                end
                FILL, RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            col_q      <= '0;
                            row_q      <= '0;
                            last_acc_q <= 1'b1;
                        end else if (col_q == CW'(IMG_W - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                        if ((state_q == FILL) && (row_q == RW'(2)) && (col_q == CW'(2))) begin
                            state_q <= RUN;
                        end
                    end
                    if (last_hs) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cnt_q <= '0;
        end else if (edge_valid_q && edge_ready && edge_data_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign edge_count = cnt_q;
`endif

    assign win_p0     = win_q[P0];
    assign win_p1     = win_q[P1];
    assign win_p2     = win_q[P2];
    assign win_p3     = win_q[P3];
    assign win_p4     = win_q[P4];
    assign win_p5     = win_q[P5];
    assign win_p6     = win_q[P6];
    assign win_p7     = win_q[P7];
    assign win_p8     = win_q[P8];
    assign win_t      = thr_q;
    assign edge_valid = edge_valid_q;
    assign edge_data  = edge_data_q;
    assign busy       = (state_q == FILL) || (state_q == RUN);
    assign done       = done_q;

endmodule
